// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one instruction at a time
// over a request/ready handshake, holds it for the datapath, and selects the
// next PC from the control unit's jump/branch/PCWre outputs and the ALU zero flag.
module instr_fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        PCWre,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        imem_err
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} stateT;

  localparam logic [31:0] TIMEOUT_LIM = IMEM_TIMEOUT;

  stateT       stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] instrReg;
  logic        imemReqReg;
  logic        imemErrReg;
  logic [31:0] waitCnt;
  logic [31:0] pcPlus4;
  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;
  logic        accept;
  logic        waiting;

  assign pcPlus4      = pcReg + 32'd4;
  assign jumpTarget   = {pcPlus4[31:28], instrReg[25:0], 2'b00};
  assign branchTarget = pcPlus4 + {{14{instrReg[15]}}, instrReg[15:0], 2'b00};

  // A response only counts while the request is actually on the bus.
  assign accept  = (stateReg == FETCH) && imemReqReg && imem_ready;
  assign waiting = (stateReg == FETCH) && imemReqReg && !imem_ready;

  // Next-state and next-PC selection; PCWre=0 outranks jump, which outranks branch.
  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    case (stateReg)
      FETCH: begin
        if (accept) begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (instr_ack) begin
          if (!PCWre) begin
            stateNext = HALT;
          end else begin
            stateNext = FETCH;
            if (jump) begin
              pcNext = jumpTarget;
            end else if (branch && zero) begin
              pcNext = branchTarget;
            end else begin
              pcNext = pcPlus4;
            end
          end
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // State, PC, request and instruction latch; the request is registered so it
  // stays low during reset and rises on the first cycle after reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= FETCH;
      pcReg      <= {RESET_PC[31:2], 2'b00};
      imemReqReg <= 1'b0;
      instrReg   <= 32'h0;
    end else begin
      stateReg   <= stateNext;
      pcReg      <= pcNext;
      imemReqReg <= (stateNext == FETCH);
      if (accept) begin
        instrReg <= imem_rdata;
      end
    end
  end

  // Fetch-wait counter and sticky timeout flag; the counter restarts per fetch
  // and saturates at the limit so it never wraps while memory stays stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt    <= 32'h0;
      imemErrReg <= 1'b0;
    end else if (stateReg != FETCH || accept) begin
      waitCnt <= 32'h0;
    end else if (waiting && (TIMEOUT_LIM != 32'h0)) begin
      if (waitCnt != TIMEOUT_LIM) begin
        waitCnt <= waitCnt + 32'd1;
      end
      if (waitCnt + 32'd1 == TIMEOUT_LIM) begin
        imemErrReg <= 1'b1;
      end
    end
  end

  assign imem_req    = imemReqReg;
  assign imem_addr   = pcReg;
  assign instr       = instrReg;
  assign op          = instrReg[31:26];
  assign instr_valid = (stateReg == EXEC);
  assign pc          = pcReg;
  assign pc_plus4    = pcPlus4;
  assign halted      = (stateReg == HALT);
  assign imem_err    = imemErrReg;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios followed by random
// instructions, all checked against a PC model built from the MIPS rules.
module tb_instr_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_ack;
  logic        jump;
  logic        branch;
  logic        zero;
  logic        PCWre;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        imem_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelPc;
  logic        errModel;

  instr_fetch_sequencer #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .jump(jump), .branch(branch), .zero(zero), .PCWre(PCWre),
    .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MIPS next-PC rules written as plain arithmetic.
  function automatic logic [31:0] nextPcModel(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = curPc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ({6'b0, word[25:0]} * 32'd4);
    if (b && z) begin
      off = $signed(word[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic doReset();
    reset = 1'b1; imem_ready = 1'b0; instr_ack = 1'b0;
    tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", imem_err, 1'b0);
    reset = 1'b0;
    modelPc = RST_PC;
    errModel = 1'b0;
  endtask

  // Wait for the request, stall for 'waits' cycles, then return 'word'.
  task automatic fetch(input logic [31:0] word, input int waits, input bit noise);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 4) begin
      imem_ready = 1'b0;
      tick();
      n++;
    end
    check("req_up", imem_req, 1'b1);
    check("addr", imem_addr, modelPc);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      if (noise) begin
        instr_ack = 1'($urandom); jump = 1'($urandom); branch = 1'($urandom);
        zero = 1'($urandom); PCWre = 1'($urandom);
      end
      tick();
      if (w + 1 == TO) errModel = 1'b1;
      check("req_hold", imem_req, 1'b1);
      check("addr_hold", imem_addr, modelPc);
      check("err_wait", imem_err, errModel);
    end
    instr_ack = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("valid_up", instr_valid, 1'b1);
    check("req_drop", imem_req, 1'b0);
    check("instr", instr, word);
    check("op", op, word[31:26]);
    check("pc_exec", pc, modelPc);
    check("pc_plus4", pc_plus4, modelPc + 32'd4);
    check("err_accept", imem_err, errModel);
  endtask

  // Hold the instruction for 'delay' cycles, then acknowledge with the given controls.
  task automatic exec(input logic [31:0] word, input logic j, input logic b, input logic z,
                      input logic we, input int delay, input bit noise);
    logic [31:0] expPc;
    for (int d = 0; d < delay; d++) begin
      instr_ack = 1'b0;
      imem_ready = noise ? 1'($urandom) : 1'b0;
      imem_rdata = $urandom;
      jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom); PCWre = 1'($urandom);
      tick();
      check("instr_stable", instr, word);
      check("valid_hold", instr_valid, 1'b1);
    end
    imem_ready = noise ? 1'($urandom) : 1'b0;
    jump = j; branch = b; zero = z; PCWre = we;
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    imem_ready = 1'b0;
    if (!we) begin
      $display("instr pc=%h word=%h halt", modelPc, word);
      check("halt_flag", halted, 1'b1);
      check("halt_valid", instr_valid, 1'b0);
      check("halt_req", imem_req, 1'b0);
      check("halt_pc", pc, modelPc);
    end else begin
      expPc = nextPcModel(modelPc, word, j, b, z);
      $display("instr pc=%h word=%h j=%0d b=%0d z=%0d next=%h", modelPc, word, j, b, z, expPc);
      modelPc = expPc;
      check("valid_drop", instr_valid, 1'b0);
      check("next_pc", pc, expPc);
      check("not_halted", halted, 1'b0);
      check("refetch_req", imem_req, 1'b1);
    end
  endtask

  initial begin
    logic [31:0] word;
    logic        rj, rb, rz, rw;
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; instr_ack = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; PCWre = 1'b1;
    modelPc = RST_PC; errModel = 1'b0;
    tick();
    doReset();

    // addi with two wait cycles, sequential ack
    fetch(32'h2008_0005, 2, 1'b0);
    check("addi_op", op, 6'b001000);
    exec(32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    check("addi_next", pc, 32'h0000_0004);

    // jump to 0x40, then beq taken and not taken
    fetch(32'h0800_0010, 0, 1'b0);
    exec(32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("j_to_40", pc, 32'h0000_0040);
    fetch(32'h1000_FFFE, 1, 1'b0);
    exec(32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("beq_taken", pc, 32'h0000_003C);
    fetch(32'h0000_0000, 0, 1'b0);
    exec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    fetch(32'h1000_FFFE, 0, 1'b0);
    exec(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("beq_not_taken", pc, 32'h0000_0044);

    // climb into the 0x1000_0000 region, then the reference jump
    fetch(32'h0BFF_FFFF, 0, 1'b0);
    exec(32'h0BFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("j_region_edge", pc, 32'h0FFF_FFFC);
    fetch(32'h0000_0000, 0, 1'b0);
    exec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    fetch(32'h0800_0004, 0, 1'b0);
    exec(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("j_to_10000010", pc, 32'h1000_0010);
    fetch(32'h0800_0100, 0, 1'b0);
    exec(32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("j_to_10000400", pc, 32'h1000_0400);

    // backward branch below zero wraps, then sequential wrap to zero
    doReset();
    fetch(32'h1000_FFFE, 0, 1'b0);
    exec(32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("branch_wrap", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0, 1'b0);
    exec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("seq_wrap", pc, 32'h0000_0000);

    // reset while waiting on memory, then re-fetch from the reset PC
    fetch(32'h0800_0020, 0, 1'b0);
    exec(32'h0800_0020, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    imem_ready = 1'b0;
    tick();
    tick();
    check("wait_req", imem_req, 1'b1);
    doReset();
    fetch(32'h2008_0001, 1, 1'b0);
    exec(32'h2008_0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // halt and stay halted regardless of bus activity
    fetch(32'hFC00_0000, 0, 1'b0);
    exec(32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom);
      instr_ack = 1'($urandom);
      PCWre = 1'($urandom);
      tick();
      check("halt_stay_req", imem_req, 1'b0);
      check("halt_stay_flag", halted, 1'b1);
      check("halt_stay_pc", pc, modelPc);
    end
    doReset();
    fetch(32'h0000_0000, 0, 1'b0);
    exec(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // timeout: err after four wait cycles, instruction still accepted
    fetch(32'h2008_0007, 6, 1'b0);
    check("timeout_err", imem_err, 1'b1);
    exec(32'h2008_0007, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("timeout_sticky", imem_err, 1'b1);
    doReset();

    // random instructions with noise on ignored inputs
    for (int k = 0; k < 80; k++) begin
      word = $urandom;
      rj = 1'($urandom); rb = 1'($urandom); rz = 1'($urandom);
      rw = ($urandom_range(0, 15) != 0);
      fetch(word, $urandom_range(0, 5), 1'b1);
      exec(word, rj, rb, rz, rw, $urandom_range(0, 2), 1'b1);
      if (!rw) begin
        for (int i = 0; i < 3; i++) begin
          tick();
          check("rand_halt_req", imem_req, 1'b0);
          check("rand_halt_pc", pc, modelPc);
        end
        doReset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
